// File: rtl/gray_code_counter.sv
`default_nettype none
// ============================================================================
// Module      : gray_code_counter
// Description : Parametrised up/down counter holding a binary count and a
//               registered Gray-code copy of it. The Gray value is derived
//               from the next binary value and registered on the same edge,
//               so gray_out has zero latency relative to bin_out, comes
//               straight from a flop and changes exactly one bit per step.
//               Suitable as a CDC FIFO pointer or a position-encoder source.
//
// Parameters  : WIDTH     - counter width in bits (>= 2)
//               RESET_VAL - binary count applied on reset
//               SATURATE  - 0: wrap at the ends, 1: hold at all-ones / zero
//
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               en        - count enable, one step per clock while high
//               up_dn     - 1 = count up, 0 = count down
//               load      - synchronous load, has priority over en
//               load_gray - 1 = load_val is Gray code, 0 = load_val is binary
//               load_val  - value to load
//               bin_out   - registered binary count
//               gray_out  - registered Gray code of bin_out
//               tc        - combinational terminal count (pending wrap/saturate)
//               wrap      - registered one-cycle pulse after a wrap-around step
//
// Revision    : 1.0 - initial release
// ============================================================================
module gray_code_counter #(
    parameter int WIDTH     = 4,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic             load_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_all_ones   = '1;
    localparam logic [WIDTH-1:0] c_zero       = '0;
    localparam logic [WIDTH-1:0] c_one        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_reset_bin  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_reset_gray = c_reset_bin ^ (c_reset_bin >> 1);
    localparam logic             c_saturate   = (SATURATE != 0);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_load_bin;
    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_next_wrap;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_at_term;

    // ------------------------------------------------------------------------
    // Gray-to-binary conversion of the load value: each binary bit is the XOR
    // of all Gray bits at or above it, rippling down from the MSB.
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_bin = load_val;
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_load_bin[i] = w_load_bin[i+1] ^ load_val[i];
        end
    end

    // ------------------------------------------------------------------------
    // Terminal detection: the current value is at the end of the range in the
    // direction of travel, so an enabled step would wrap or saturate.
    // ------------------------------------------------------------------------
    assign w_at_max  = (r_bin == c_all_ones);
    assign w_at_min  = (r_bin == c_zero);
    assign w_at_term = up_dn ? w_at_max : w_at_min;

    // Combinational on purpose so an upstream stage sees the pending wrap in
    // the same cycle; a load overrides the step and therefore masks it.
    assign tc = en & ~load & w_at_term;

    // ------------------------------------------------------------------------
    // Next binary value: load > en > hold.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_bin  = r_bin;
        w_next_wrap = 1'b0;
        if (load) begin
            w_next_bin = load_gray ? w_load_bin : load_val;
        end else if (en) begin
            if (w_at_term && c_saturate) begin
                // Saturating at the end of the range: hold, never pulse wrap.
                w_next_bin = r_bin;
            end else begin
                w_next_bin  = up_dn ? (r_bin + c_one) : (r_bin - c_one);
                w_next_wrap = w_at_term;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Binary-to-Gray of the next value, registered alongside the binary count
    // so the Gray output is glitch-free and has no combinational path out.
    // ------------------------------------------------------------------------
    assign w_next_gray[WIDTH-1] = w_next_bin[WIDTH-1];

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_b2g
            assign w_next_gray[gi] = w_next_bin[gi+1] ^ w_next_bin[gi];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_reset_bin;
            r_gray <= c_reset_gray;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_wrap <= w_next_wrap;
        end
    end

    assign bin_out  = r_bin;
    assign gray_out = r_gray;
    assign wrap     = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_code_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_gray_code_counter
// Description : Self-checking bench for gray_code_counter. Three 4-bit
//               instances share one stimulus stream:
//                 [0] RESET_VAL=0, wrapping
//                 [1] RESET_VAL=0, saturating
//                 [2] RESET_VAL=5, wrapping
//               An integer reference model predicts every output; a compare
//               process checks all instances each falling edge, and directed
//               sequences pin hand-computed literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_code_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int N    = 3;
    localparam int RV  [N] = '{0, 0, 5};
    localparam bit SAT [N] = '{1'b0, 1'b1, 1'b0};

    logic           clk;
    logic           rst_n;
    logic           en;
    logic           up_dn;
    logic           load;
    logic           load_gray;
    logic [W-1:0]   load_val;

    logic [N-1:0][W-1:0] bin_o;
    logic [N-1:0][W-1:0] gray_o;
    logic [N-1:0]        tc_o;
    logic [N-1:0]        wrap_o;

    int n_cmp;
    int n_fail;

    int m_bin  [N];
    bit m_wrap [N];

    gray_code_counter #(.WIDTH(W), .RESET_VAL(0), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_out(bin_o[0]), .gray_out(gray_o[0]), .tc(tc_o[0]), .wrap(wrap_o[0])
    );

    gray_code_counter #(.WIDTH(W), .RESET_VAL(0), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_out(bin_o[1]), .gray_out(gray_o[1]), .tc(tc_o[1]), .wrap(wrap_o[1])
    );

    gray_code_counter #(.WIDTH(W), .RESET_VAL(5), .SATURATE(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_gray(load_gray), .load_val(load_val),
        .bin_out(bin_o[2]), .gray_out(gray_o[2]), .tc(tc_o[2]), .wrap(wrap_o[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------------
    // Reference model: plain integer arithmetic on the count.
    // ------------------------------------------------------------------------
    function automatic int to_gray(int b);
        return b ^ (b >> 1);
    endfunction

    // Binary value is the prefix XOR of all right-shifts of the Gray value.
    function automatic int from_gray(int g);
        int b;
        b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b;
    endfunction

    function automatic int model_next(int cur, bit sat);
        int t;
        if (load) return load_gray ? from_gray(int'(load_val)) : int'(load_val);
        if (!en) return cur;
        t = up_dn ? cur + 1 : cur - 1;
        if (t < 0 || t > MAXV) return sat ? cur : (t + MAXV + 1) % (MAXV + 1);
        return t;
    endfunction

    function automatic bit model_wraps(int cur, bit sat);
        return !load && en && !sat && ((up_dn && cur == MAXV) || (!up_dn && cur == 0));
    endfunction

    function automatic bit model_tc(int cur);
        return en && !load && (up_dn ? (cur == MAXV) : (cur == 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_bin[k]  <= RV[k];
                m_wrap[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                m_bin[k]  <= model_next(m_bin[k], SAT[k]);
                m_wrap[k] <= model_wraps(m_bin[k], SAT[k]);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Every falling edge: all outputs of all instances against the model.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            chk($sformatf("model_bin[%0d]", k),  int'(bin_o[k]),  m_bin[k]);
            chk($sformatf("model_gray[%0d]", k), int'(gray_o[k]), to_gray(m_bin[k]));
            chk($sformatf("model_wrap[%0d]", k), int'(wrap_o[k]), int'(m_wrap[k]));
            chk($sformatf("model_tc[%0d]", k),   int'(tc_o[k]),   int'(model_tc(m_bin[k])));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the rising edge.
    // ------------------------------------------------------------------------
    task automatic set_in(input bit e, input bit u, input bit l, input bit lg, input int lv);
        en        = e;
        up_dn     = u;
        load      = l;
        load_gray = lg;
        load_val  = lv[W-1:0];
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        int prev_g;
        bit dir;
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        set_in(0, 0, 0, 0, 0);
        #7;
        rst_n = 1'b1;

        // Reset values.
        chk("rst_bin0",  int'(bin_o[0]),  0);
        chk("rst_gray0", int'(gray_o[0]), 0);
        chk("rst_wrap0", int'(wrap_o[0]), 0);
        chk("rst_bin2",  int'(bin_o[2]),  5);
        chk("rst_gray2", int'(gray_o[2]), 7);

        // Up count through the whole Gray sequence.
        set_in(1, 1, 0, 0, 0);
        prev_g = 0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("seq_gray[%0d]", i), int'(gray_o[0]), gtab[i]);
            chk($sformatf("seq_bin[%0d]", i),  int'(bin_o[0]),  i);
            if (i > 0) chk($sformatf("one_bit[%0d]", i), $countones(int'(gray_o[0]) ^ prev_g), 1);
            prev_g = int'(gray_o[0]);
            if (i < 15) tick();
        end

        // Wrap up from all-ones.
        chk("tc_up_term", int'(tc_o[0]), 1);
        tick();
        chk("wrap_up_bin",  int'(bin_o[0]),  0);
        chk("wrap_up_gray", int'(gray_o[0]), 0);
        chk("wrap_up_pulse", int'(wrap_o[0]), 1);
        chk("sat_bin_first", int'(bin_o[1]), 15);
        for (int j = 0; j < 3; j++) begin
            tick();
            if (j == 0) chk("wrap_up_clear", int'(wrap_o[0]), 0);
            chk($sformatf("sat_bin[%0d]", j),  int'(bin_o[1]),  15);
            chk($sformatf("sat_gray[%0d]", j), int'(gray_o[1]), 8);
            chk($sformatf("sat_wrap[%0d]", j), int'(wrap_o[1]), 0);
            chk($sformatf("sat_tc[%0d]", j),   int'(tc_o[1]),   1);
        end

        // Loads in Gray and binary form; load beats en on the terminal value.
        set_in(0, 1, 1, 1, 'b1011);
        tick();
        chk("gload_bin",  int'(bin_o[0]),  13);
        chk("gload_gray", int'(gray_o[0]), 'b1011);
        set_in(0, 1, 1, 0, 'b1011);
        tick();
        chk("bload_bin",  int'(bin_o[0]),  'b1011);
        chk("bload_gray", int'(gray_o[0]), 'b1110);
        set_in(0, 1, 1, 0, 15);
        tick();
        set_in(1, 1, 1, 0, 3);
        #1;
        chk("load_masks_tc", int'(tc_o[0]), 0);
        tick();
        chk("load_over_en_bin",  int'(bin_o[0]),  3);
        chk("load_over_en_wrap", int'(wrap_o[0]), 0);

        // Down count and wrap.
        set_in(0, 0, 1, 0, 1);
        tick();
        set_in(1, 0, 0, 0, 0);
        tick();
        chk("down_bin0", int'(bin_o[0]), 0);
        chk("down_tc",   int'(tc_o[0]),  1);
        tick();
        chk("down_wrap_bin",  int'(bin_o[0]),  15);
        chk("down_wrap_gray", int'(gray_o[0]), 8);
        chk("down_wrap_pulse", int'(wrap_o[0]), 1);
        tick();
        chk("down_bin14",  int'(bin_o[0]),  14);
        chk("down_gray14", int'(gray_o[0]), 9);
        chk("down_wrap_clear", int'(wrap_o[0]), 0);

        // Asynchronous reset mid-cycle on the RESET_VAL=5 instance.
        set_in(0, 1, 1, 0, 'b1010);
        tick();
        chk("pre_rst_bin2", int'(bin_o[2]), 10);
        set_in(0, 1, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bin2",  int'(bin_o[2]),  5);
        chk("async_rst_gray2", int'(gray_o[2]), 7);
        set_in(1, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("post_rst_bin2",  int'(bin_o[2]),  6);
        chk("post_rst_gray2", int'(gray_o[2]), 5);

        // Randomised phase, biased toward long runs in one direction.
        dir = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 19) == 0) dir = ~dir;
            set_in(($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 9) == 0) ? ~dir : dir,
                   ($urandom_range(0, 11) == 0),
                   $urandom_range(0, 1) == 1,
                   int'($urandom_range(0, MAXV)));
            if ($urandom_range(0, 99) == 0) begin
                #1;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_code_counter.md
Name: gray_code_counter

Overview:
Parametrised up/down counter that keeps a binary count and a registered, glitch-free Gray-code copy of it. It generalises the team's 4-bit binary-to-Gray converter to any width. It adds loadable start values in binary or Gray form, wrap/saturate modes and terminal-count flags. It feeds Gray pointers to clock-domain-crossing FIFOs and drives position encoders.

Parameters:
WIDTH, 4, counter width in bits (>= 2)
RESET_VAL, 0, binary count value applied on reset (must fit in WIDTH)
SATURATE, 0, 0 = wrap around at the ends; 1 = hold at all-ones (up) or zero (down)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; one step per clock while high
up_dn  input  1  1 = count up, 0 = count down
load  input  1  synchronous load; takes priority over en
load_gray  input  1  1 = load_val is Gray code and is converted to binary before loading; 0 = load_val is binary
load_val  input  WIDTH  value to load
bin_out  output  WIDTH  registered binary count
gray_out  output  WIDTH  registered Gray code of bin_out
tc  output  1  combinational terminal count: en & ~load & (up_dn ? bin_out==all-ones : bin_out==0)
wrap  output  1  registered one-cycle pulse in the cycle after a wrap-around step

Behaviour:
- Reset (rst_n low, asynchronous): bin_out=RESET_VAL, gray_out=Gray(RESET_VAL), wrap=0. Effective immediately, even mid-count. The first step after release happens on the first rising edge with rst_n high.
- Binary-to-Gray conversion: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i].
- Gray-to-binary conversion (used for load_gray=1): b[W-1]=g[W-1]; b[i]=b[i+1]^g[i], a ripple from the MSB.
- Priority on each rising edge: load > en > hold.
- load=1: bin_out <= load_val, or its binary conversion when load_gray=1. gray_out <= Gray of the loaded binary value. wrap <= 0. en is ignored.
- en=1, load=0, up_dn=1: bin_out <= bin_out+1, modulo 2^WIDTH.
- en=1, load=0, up_dn=0: bin_out <= bin_out-1, modulo 2^WIDTH.
- en=0, load=0: all registers hold, and wrap <= 0.
- gray_out is computed from the next binary value and registered in the same edge as bin_out. Zero latency relative to bin_out, no combinational path to the output, and exactly one bit changes per count step.
- SATURATE=0: stepping up from all-ones gives 0, and stepping down from 0 gives all-ones. wrap <= 1 for exactly the cycle after that edge, otherwise wrap <= 0.
- SATURATE=1: a step that would wrap leaves bin_out and gray_out unchanged, and wrap stays 0 permanently.
- tc lets an upstream stage see a pending wrap or saturation in the same cycle.
- load and en both high on the terminal value: the load wins and wrap stays 0.
- Changing up_dn between cycles is legal; each step uses the current up_dn.

Test Plan:
- Reset then up-count (WIDTH=4, RESET_VAL=0, en=1, up_dn=1), 16 cycles -> gray_out sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000. Exactly one bit changes per step and bin_out matches 0..15.
- Wrap up: continue from bin 1111 (gray 1000), en=1 -> tc=1 in that cycle; next edge bin_out=0000, gray_out=0000, wrap=1 for one cycle, then 0.
- Gray load: load=1, load_gray=1, load_val=1011 -> bin_out=1101 (13), gray_out=1011. Same with load_gray=0 -> bin_out=1011, gray_out=1110. Load with en=1 at bin 1111 -> no wrap pulse.
- Down count and wrap: load 0001, up_dn=0, en=1, 3 cycles -> bin 0000 (tc=1), then 1111 with gray 1000 and wrap=1, then 1110 with gray 1001.
- Saturate (SATURATE=1): count up to 1111 and hold en=1 for 3 more cycles -> bin_out stays 1111, gray_out stays 1000, wrap never 1, tc stays 1.
- Asynchronous reset mid-count (RESET_VAL=5): assert rst_n low between edges at bin 1010 -> bin_out=0101 and gray_out=0111 immediately without a clock. After release with en=1, the next edge gives bin 0110, gray 0101.
